// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage. Holds the ALU, the load/store address path,
// the HI/LO pair, a single-cycle multiplier and a 32-step restoring divider.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 145,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int ES_TO_DS_BUS_WD = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  // divider state | meaning
  // S_IDLE        | no division in progress; operands latched on entry
  // S_BUSY        | one restoring step per cycle, r_cnt = step index
  // S_DONE        | quotient/remainder ready, waiting for fire
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  logic                       r_valid;
  logic [DS_TO_ES_BUS_WD-1:0] r_bus;
  div_state_t                 r_state;
  logic [4:0]                 r_cnt;
  logic [31:0]                r_quo, r_rem, r_dsr, r_hi, r_lo;
  logic                       r_q_neg, r_r_neg;

  logic [7:0]  w_md_op;
  logic [11:0] w_alu_op;
  logic        w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm;
  logic        w_src2_is_zimm, w_src2_is_8, w_gr_we, w_mem_we;
  logic [4:0]  w_dest;
  logic [15:0] w_imm;
  logic [31:0] w_rs, w_rt, w_pc;

  assign {w_md_op, w_alu_op, w_load_op, w_src1_is_sa, w_src1_is_pc, w_src2_is_imm,
          w_src2_is_zimm, w_src2_is_8, w_gr_we, w_mem_we, w_dest, w_imm,
          w_rs, w_rt, w_pc} = r_bus;

  logic w_is_div, w_ready_go, w_fire;
  assign w_is_div       = w_md_op[5] | w_md_op[4];
  assign w_ready_go     = !w_is_div || (r_state == S_DONE);
  assign w_fire         = r_valid & w_ready_go & ms_allowin;
  assign es_allowin     = !r_valid || (w_ready_go && ms_allowin);
  assign es_to_ms_valid = r_valid & w_ready_go;

  always_ff @(posedge clk) begin
    if (reset)           r_valid <= 1'b0;
    else if (es_allowin) r_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) r_bus <= ds_to_es_bus;
  end

  logic [31:0] w_src1, w_src2, w_add, w_sub, w_slt, w_sltu, w_sra, w_alu, w_result;
  assign w_src1 = w_src1_is_sa ? {27'd0, w_imm[10:6]} : (w_src1_is_pc ? w_pc : w_rs);
  assign w_src2 = w_src2_is_imm  ? {{16{w_imm[15]}}, w_imm} :
                  w_src2_is_zimm ? {16'd0, w_imm} :
                  w_src2_is_8    ? 32'd8 : w_rt;
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
  assign w_sltu = {31'd0, (w_src1 < w_src2)};
  assign w_sra  = $signed(w_src2) >>> w_src1[4:0];
  assign w_alu  = ({32{w_alu_op[11]}} & w_add)
                | ({32{w_alu_op[10]}} & w_sub)
                | ({32{w_alu_op[9]}}  & w_slt)
                | ({32{w_alu_op[8]}}  & w_sltu)
                | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
                | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
                | ({32{w_alu_op[1]}}  & w_sra)
                | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'd0});
  assign w_result = w_md_op[3] ? r_hi : (w_md_op[2] ? r_lo : w_alu);

  assign es_to_ms_bus    = {w_load_op, w_gr_we, w_dest, w_result, w_pc};
  assign es_to_ds_bus    = (r_valid && w_gr_we) ? w_dest : 5'd0;
  assign data_sram_en    = r_valid & (w_load_op | w_mem_we) & ms_allowin;
  assign data_sram_wen   = {4{r_valid & w_mem_we & ms_allowin}};
  assign data_sram_addr  = w_alu;
  assign data_sram_wdata = w_rt;

  logic [63:0] w_mul_s, w_mul_u;
  assign w_mul_s = {{32{w_rs[31]}}, w_rs} * {{32{w_rt[31]}}, w_rt};
  assign w_mul_u = {32'd0, w_rs} * {32'd0, w_rt};

  // Sign handling wraps an unsigned core; divu passes operands through raw.
  logic [31:0] w_dvd_abs, w_dsr_abs, w_div_sub, w_quo_fix, w_rem_fix;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  assign w_dvd_abs = (w_md_op[5] && w_rs[31]) ? (32'd0 - w_rs) : w_rs;
  assign w_dsr_abs = (w_md_op[5] && w_rt[31]) ? (32'd0 - w_rt) : w_rt;
  assign w_div_sh  = {r_rem, r_quo[31]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_dsr});
  assign w_div_sub = w_div_sh[31:0] - r_dsr;
  assign w_quo_fix = r_q_neg ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dsr   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_valid && w_is_div) begin
          r_state <= S_BUSY;
          r_cnt   <= '0;
          r_quo   <= w_dvd_abs;
          r_rem   <= '0;
          r_dsr   <= w_dsr_abs;
          r_q_neg <= w_md_op[5] & (w_rs[31] ^ w_rt[31]);
          r_r_neg <= w_md_op[5] & w_rs[31];
        end
        S_BUSY: begin
          r_rem <= w_div_ge ? w_div_sub : w_div_sh[31:0];
          r_quo <= {r_quo[30:0], w_div_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DONE;
        end
        S_DONE:  if (w_fire) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fire) begin
      if (w_md_op[7])      {r_hi, r_lo} <= w_mul_s;
      else if (w_md_op[6]) {r_hi, r_lo} <= w_mul_u;
      else if (w_is_div) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        if (w_md_op[1]) r_hi <= w_rs;
        if (w_md_op[0]) r_lo <= w_rs;
      end
    end
  end
endmodule
